// File: rtl/word_reconstructor.sv
// word_reconstructor
//   Rebuilds 32-bit words from compressed tokens. A move-to-front dictionary
//   is kept identical to the compressor's, so a hit token only has to carry a
//   location plus a per-byte mask, and literal bytes fill the rest.
//
// Ports
//   i_clk, i_rst_n    clock (rising edge), async active-low reset
//   i_flush           sync clear of output valid, dictionary count and error
//   i_valid/o_ready   token handshake (hit, loc, mask, literal)
//   o_valid/i_ready   reconstructed-word handshake (o_word)
//   o_dict_count      number of valid dictionary entries, 0..DICT_DEPTH
//   o_err             sticky: a hit referenced an entry beyond o_dict_count

// One byte lane: dictionary byte when the lane is masked in, else literal.
module word_reconstructor_lane (
  input  logic       use_dict,
  input  logic [7:0] dict_byte,
  input  logic [7:0] lit_byte,
  output logic [7:0] res_byte
);
  assign res_byte = use_dict ? dict_byte : lit_byte;
endmodule

module word_reconstructor #(
  parameter  int WORD       = 32,
  parameter  int DICT_DEPTH = 16,
  localparam int LOC_W      = $clog2(DICT_DEPTH),
  localparam int NUM_LANES  = WORD / 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_hit,
  input  logic [LOC_W-1:0]     i_loc,
  input  logic [NUM_LANES-1:0] i_mask,
  input  logic [WORD-1:0]      i_literal,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD-1:0]      o_word,
  output logic [LOC_W:0]       o_dict_count,
  output logic                 o_err
);

  localparam logic [LOC_W:0] FULL = (LOC_W+1)'(DICT_DEPTH);

  typedef struct packed {
    logic                          hit;
    logic [LOC_W-1:0]              loc;
    logic [NUM_LANES-1:0]          mask;
    logic [NUM_LANES-1:0][7:0]     literal;
  } tok_t;

  tok_t                                     tok;
  logic [DICT_DEPTH-1:0][NUM_LANES-1:0][7:0] dict;
  logic [NUM_LANES-1:0][7:0]                dict_sel;
  logic [NUM_LANES-1:0][7:0]                result;
  logic                                     accept;
  logic                                     loc_ok;
  logic                                     hit_ok;
  logic                                     dict_upd;

  always_comb begin
    tok         = '0;
    tok.hit     = i_hit;
    tok.loc     = i_loc;
    tok.mask    = i_mask;
    tok.literal = i_literal;
  end

  assign o_ready  = ~i_flush & (~o_valid | i_ready);
  assign accept   = i_valid & o_ready;
  assign dict_sel = dict[tok.loc];
  // Location must point at a populated entry; otherwise the hit is treated
  // as a literal and the dictionary is left alone.
  assign loc_ok   = {1'b0, tok.loc} < o_dict_count;
  assign hit_ok   = tok.hit & loc_ok;
  assign dict_upd = accept & (~tok.hit | loc_ok);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    word_reconstructor_lane u_lane (
      .use_dict  (hit_ok & tok.mask[g]),
      .dict_byte (dict_sel[g]),
      .lit_byte  (tok.literal[g]),
      .res_byte  (result[g])
    );
  end

  // Move-to-front: a miss shifts every entry (last one falls off), a hit
  // shifts only the entries above the hit location; the result goes to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dict <= '0;
    end else if (dict_upd) begin
      dict[0] <= result;
      for (int i = 1; i < DICT_DEPTH; i++) begin
        if (!tok.hit || i <= int'(tok.loc))
          dict[i] <= dict[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_word       <= '0;
      o_dict_count <= '0;
      o_err        <= 1'b0;
    end else if (i_flush) begin
      // Entries are left stale; count = 0 makes them unreachable.
      o_valid      <= 1'b0;
      o_dict_count <= '0;
      o_err        <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_word  <= result;
      if (tok.hit && !loc_ok)
        o_err <= 1'b1;
      if (!tok.hit && o_dict_count != FULL)
        o_dict_count <= o_dict_count + 1'b1;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_word_reconstructor.sv
module tb_word_reconstructor;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, i_hit, i_ready;
  logic [3:0]  i_loc, i_mask;
  logic [31:0] i_literal;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_word;
  logic [4:0]  o_dict_count;

  int errors = 0;
  int checks = 0;

  // Reference: dictionary as a queue, index 0 = most recent.
  logic [31:0] mq[$];
  logic        merr;
  logic [31:0] exp_w, held_w;
  logic [31:0] words[17];

  always #5 i_clk = ~i_clk;

  word_reconstructor dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_hit(i_hit), .i_loc(i_loc),
    .i_mask(i_mask), .i_literal(i_literal), .o_valid(o_valid),
    .i_ready(i_ready), .o_word(o_word), .o_dict_count(o_dict_count),
    .o_err(o_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic hit, input int loc, input logic [3:0] mask,
                             input logic [31:0] lit, output logic [31:0] r);
    if (!hit) begin
      r = lit;
      mq.push_front(r);
      if (mq.size() > 16) void'(mq.pop_back());
    end else if (loc >= mq.size()) begin
      merr = 1'b1;
      r = lit;
    end else begin
      for (int k = 0; k < 4; k++)
        r[8*k +: 8] = mask[k] ? mq[loc][8*k +: 8] : lit[8*k +: 8];
      mq.delete(loc);
      mq.push_front(r);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    merr = 1'b0;
  endtask

  // Present one token with i_ready=1, expect it accepted on the next edge.
  task automatic send(input string tag, input logic hit, input logic [3:0] loc,
                      input logic [3:0] mask, input logic [31:0] lit);
    i_hit = hit; i_loc = loc; i_mask = mask; i_literal = lit; i_valid = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(o_ready), 32'd1);
    @(posedge i_clk);
    model_apply(hit, int'(loc), mask, lit, exp_w);
    #1;
    i_valid = 1'b0;
    check({tag, ".valid"}, 32'(o_valid), 32'd1);
    check({tag, ".word"},  o_word, exp_w);
    check({tag, ".count"}, 32'(o_dict_count), 32'(mq.size()));
    check({tag, ".err"},   32'(o_err), 32'(merr));
  endtask

  task automatic idle_drain(input string tag);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    check({tag, ".drain"}, 32'(o_valid), 32'd0);
  endtask

  task automatic do_flush(input string tag);
    i_flush = 1'b1; i_valid = 1'b1; i_hit = 1'b0; i_literal = 32'hF1F1F1F1;
    #1;
    check({tag, ".ready"}, 32'(o_ready), 32'd0);
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    model_clear();
    check({tag, ".valid"}, 32'(o_valid), 32'd0);
    check({tag, ".count"}, 32'(o_dict_count), 32'd0);
    check({tag, ".err"},   32'(o_err), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_hit = 1'b0;
    i_loc = '0; i_mask = '0; i_literal = '0; i_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.word",  o_word, 32'd0);
    check("rst.count", 32'(o_dict_count), 32'd0);
    check("rst.err",   32'(o_err), 32'd0);
    check("rst.ready", 32'(o_ready), 32'd1);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Miss fill, back-to-back
    send("t2.a0", 1'b0, 4'd0, 4'h0, 32'h11111111);
    send("t2.a1", 1'b0, 4'd3, 4'hF, 32'h22222222);
    send("t2.a2", 1'b0, 4'd0, 4'h0, 32'h33333333);
    send("t2.a3", 1'b0, 4'd0, 4'h0, 32'h44444444);
    check("t2.count4", 32'(o_dict_count), 32'd4);

    // Full hit; then walk the new order 22,44,33,11 with front hits
    send("t3.hit", 1'b1, 4'd2, 4'hF, 32'h0);
    check("t3.word", o_word, 32'h22222222);
    send("t3.ord1", 1'b1, 4'd1, 4'hF, 32'h0);
    check("t3.ord1w", o_word, 32'h44444444);
    send("t3.ord3", 1'b1, 4'd3, 4'hF, 32'h0);
    check("t3.ord3w", o_word, 32'h11111111);

    // Partial hit, result lands in entry 0
    send("t4.miss", 1'b0, 4'd0, 4'h0, 32'hAABBCCDD);
    send("t4.part", 1'b1, 4'd0, 4'b0011, 32'h55660000);
    check("t4.word", o_word, 32'h5566CCDD);
    send("t4.front", 1'b1, 4'd0, 4'hF, 32'h12345678);
    check("t4.frontw", o_word, 32'h5566CCDD);
    send("t4.zmask", 1'b1, 4'd3, 4'h0, 32'h0BADF00D);
    send("t4.zfront", 1'b1, 4'd0, 4'hF, 32'h0);
    check("t4.zfrontw", o_word, 32'h0BADF00D);

    // Overflow: 17 distinct misses
    idle_drain("t5.pre");
    do_flush("t5.flush");
    for (int i = 0; i < 17; i++) begin
      words[i] = {8'(i + 1), 24'($urandom)};
      send("t5.miss", 1'b0, 4'd0, 4'h0, words[i]);
    end
    check("t5.sat", 32'(o_dict_count), 32'd16);
    send("t5.hit15", 1'b1, 4'd15, 4'hF, 32'h0);
    check("t5.hit15w", o_word, words[1]);

    // Error on out-of-range hit
    idle_drain("t6.pre");
    do_flush("t6.flush0");
    send("t6.m0", 1'b0, 4'd0, 4'h0, 32'hCAFE0000);
    send("t6.m1", 1'b0, 4'd0, 4'h0, 32'hCAFE0001);
    send("t6.m2", 1'b0, 4'd0, 4'h0, 32'hCAFE0002);
    send("t6.bad", 1'b1, 4'd5, 4'hF, 32'h600DBEEF);
    check("t6.badw", o_word, 32'h600DBEEF);
    check("t6.erra", 32'(o_err), 32'd1);
    check("t6.cnt3", 32'(o_dict_count), 32'd3);

    // Backpressure
    idle_drain("t6.bp0");
    i_ready = 1'b0;
    i_hit = 1'b0; i_literal = 32'hDEAD0001; i_valid = 1'b1;
    #1;
    check("t6.bp.ready0", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    model_apply(1'b0, 0, 4'h0, 32'hDEAD0001, held_w);
    #1;
    i_literal = 32'hDEAD0002;
    for (int c = 0; c < 3; c++) begin
      check("t6.bp.ready", 32'(o_ready), 32'd0);
      check("t6.bp.valid", 32'(o_valid), 32'd1);
      check("t6.bp.hold",  o_word, held_w);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    #1;
    check("t6.bp.rel", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    model_apply(1'b0, 0, 4'h0, 32'hDEAD0002, exp_w);
    #1;
    i_valid = 1'b0;
    check("t6.bp.valid2", 32'(o_valid), 32'd1);
    check("t6.bp.word2",  o_word, exp_w);
    check("t6.bp.cnt",    32'(o_dict_count), 32'(mq.size()));

    // Flush with a pending token: token dropped, so a hit loc0 must error
    do_flush("t6.flush");
    send("t6.post", 1'b1, 4'd0, 4'hF, 32'h77777777);

    // Random tokens against the model
    idle_drain("rnd.pre");
    do_flush("rnd.flush");
    for (int n = 0; n < 300; n++) begin
      send("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom), $urandom);
      if ($urandom_range(0, 9) == 0) idle_drain("rnd.idle");
    end

    // Async reset mid-stream
    i_hit = 1'b0; i_literal = 32'h99999999; i_valid = 1'b1;
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t1.valid", 32'(o_valid), 32'd0);
    check("t1.count", 32'(o_dict_count), 32'd0);
    check("t1.err",   32'(o_err), 32'd0);
    check("t1.word",  o_word, 32'd0);
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_clear();
    send("t1.after", 1'b1, 4'd0, 4'hF, 32'h31313131);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
